// File: rtl/p_dispatch_multi.sv
`default_nettype none
// ============================================================================
// Module   : p_dispatch_multi
// Purpose  : Rename->issue dispatch stage. Holds one rename group of WIDTH
//            lanes and steers each lane to an ALU queue (preg mod NUM_ALU),
//            the MDU queue or the LSU queue. Lanes leave in order, one prefix
//            at a time, as their queues become ready. Source operands of a
//            held group keep capturing CDB write-backs.
// Ports    : clk/rst_n            clock, asynchronous active-low reset
//            flush_i              pipeline flush (drops held and incoming group)
//            in_*                 rename group handshake and per-lane contents
//            cdb_*                write-back ports snooped for operand wakeup
//            q_valid_o/q_ready_i  per-queue handshake, q_mask_o lanes offered
//            q_src_*/q_preg_o/q_payload_o  shared lane buses to all queues
//            rob_issue_o          one-cycle pulse per lane dispatched
// Revision : 1.0 - initial release
// ============================================================================
module p_dispatch_multi #(
   parameter int WIDTH     = 2,
   parameter int NUM_ALU   = 2,
   parameter int CDB_PORTS = 2,
   parameter int DATA_W    = 32,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 128
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic [WIDTH-1:0]                in_lane_valid_i,
   input  logic [WIDTH*2-1:0]              in_unit_i,
   input  logic [WIDTH*PREG_W-1:0]         in_preg_i,
   input  logic [WIDTH*2*PREG_W-1:0]       in_src_preg_i,
   input  logic [WIDTH*2*DATA_W-1:0]       in_src_data_i,
   input  logic [WIDTH*2-1:0]              in_src_rdy_i,
   input  logic [WIDTH*PAYLOAD_W-1:0]      in_payload_i,
   input  logic [CDB_PORTS-1:0]            cdb_valid_i,
   input  logic [CDB_PORTS*PREG_W-1:0]     cdb_preg_i,
   input  logic [CDB_PORTS*DATA_W-1:0]     cdb_data_i,
   output logic [NUM_ALU+1:0]              q_valid_o,
   input  logic [NUM_ALU+1:0]              q_ready_i,
   output logic [(NUM_ALU+2)*WIDTH-1:0]    q_mask_o,
   output logic [WIDTH*2*DATA_W-1:0]       q_src_data_o,
   output logic [WIDTH*2-1:0]              q_src_rdy_o,
   output logic [WIDTH*PREG_W-1:0]         q_preg_o,
   output logic [WIDTH*PAYLOAD_W-1:0]      q_payload_o,
   output logic [WIDTH-1:0]                rob_issue_o
);

   localparam int NUM_Q = NUM_ALU + 2;
   localparam int NOPS  = WIDTH * 2;
   localparam logic [1:0] UNIT_ALU = 2'd0;
   localparam logic [1:0] UNIT_MDU = 2'd1;
   localparam logic [1:0] UNIT_LSU = 2'd2;
   localparam logic [1:0] UNIT_ROB = 2'd3;

   // Packed views of the flat ports (operand k = lane*2 + src).
   logic [WIDTH-1:0][1:0]              in_unit;
   logic [NOPS-1:0][PREG_W-1:0]        in_src_preg;
   logic [NOPS-1:0][DATA_W-1:0]        in_src_data;
   logic [CDB_PORTS-1:0][PREG_W-1:0]   cdb_preg;
   logic [CDB_PORTS-1:0][DATA_W-1:0]   cdb_data;

   assign in_unit     = in_unit_i;
   assign in_src_preg = in_src_preg_i;
   assign in_src_data = in_src_data_i;
   assign cdb_preg    = cdb_preg_i;
   assign cdb_data    = cdb_data_i;

   // Holding register
   logic                               hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0]                   lane_valid_q, lane_valid_d;
   logic [WIDTH-1:0]                   sent_q, sent_d;
   logic [WIDTH-1:0][1:0]              unit_q, unit_d;
   logic [WIDTH-1:0][PREG_W-1:0]       preg_q, preg_d;
   logic [NOPS-1:0][PREG_W-1:0]        src_preg_q, src_preg_d;
   logic [NOPS-1:0][DATA_W-1:0]        src_data_q, src_data_d;
   logic [NOPS-1:0]                    src_rdy_q, src_rdy_d;
   logic [WIDTH-1:0][PAYLOAD_W-1:0]    payload_q, payload_d;

   // CDB matches against incoming and held source pregs
   logic [NOPS-1:0]                    in_hit, hold_hit;
   logic [NOPS-1:0][DATA_W-1:0]        in_hit_data, hold_hit_data;

   always_comb begin
      in_hit        = '0;
      hold_hit      = '0;
      in_hit_data   = '0;
      hold_hit_data = '0;
      for (int k = 0; k < NOPS; k++) begin
         for (int c = 0; c < CDB_PORTS; c++) begin
            if (cdb_valid_i[c] && cdb_preg[c] == in_src_preg[k]) begin
               in_hit[k]      = 1'b1;
               in_hit_data[k] = in_hit_data[k] | cdb_data[c];
            end
            if (cdb_valid_i[c] && cdb_preg[c] == src_preg_q[k]) begin
               hold_hit[k]      = 1'b1;
               hold_hit_data[k] = hold_hit_data[k] | cdb_data[c];
            end
         end
      end
   end

   // Lane targets as one-hot queue vectors; ROB-only lanes have no queue.
   logic [WIDTH-1:0][NUM_Q-1:0]        lane_tgt;
   logic [WIDTH-1:0]                   tgt_rdy;
   logic [WIDTH-1:0]                   pend, elig, fire;
   logic                               done;

   always_comb begin
      lane_tgt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (unit_q[i])
            UNIT_ALU: begin
               for (int q = 0; q < NUM_ALU; q++) begin
                  if (32'(preg_q[i]) % NUM_ALU == q) lane_tgt[i][q] = 1'b1;
               end
            end
            UNIT_MDU: lane_tgt[i][NUM_ALU]     = 1'b1;
            UNIT_LSU: lane_tgt[i][NUM_ALU + 1] = 1'b1;
            default:  lane_tgt[i]              = '0;
         endcase
      end
   end

   // In-order prefix: a pending lane is offered only while every lower
   // pending lane fires this cycle. The prefix survives to the end exactly
   // when the whole group completes.
   always_comb begin
      logic chain_ok;
      chain_ok = 1'b1;
      pend     = '0;
      elig     = '0;
      fire     = '0;
      tgt_rdy  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pend[i]    = hold_valid_q & lane_valid_q[i] & ~sent_q[i];
         tgt_rdy[i] = (unit_q[i] == UNIT_ROB) | (|(lane_tgt[i] & q_ready_i));
         elig[i]    = pend[i] & chain_ok;
         fire[i]    = elig[i] & tgt_rdy[i];
         chain_ok   = chain_ok & (~pend[i] | fire[i]);
      end
      done = hold_valid_q & chain_ok;
   end

   logic [NUM_Q-1:0][WIDTH-1:0]        mask;
   logic                               in_ready, accept;

   always_comb begin
      mask      = '0;
      q_valid_o = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         for (int i = 0; i < WIDTH; i++) mask[q][i] = elig[i] & lane_tgt[i][q];
         q_valid_o[q] = (|mask[q]) & ~flush_i;
      end
   end

   assign q_mask_o    = mask;
   assign rob_issue_o = fire & {WIDTH{~flush_i}};
   assign in_ready    = ~flush_i & (~hold_valid_q | done);
   assign in_ready_o  = in_ready;
   assign accept      = in_valid_i & in_ready;

   // Operand bus: captured value, else same-cycle CDB bypass.
   logic [NOPS-1:0][DATA_W-1:0]        src_data_out;
   always_comb begin
      src_data_out = '0;
      q_src_rdy_o  = '0;
      for (int k = 0; k < NOPS; k++) begin
         q_src_rdy_o[k]  = src_rdy_q[k] | (hold_valid_q & hold_hit[k]);
         src_data_out[k] = (~src_rdy_q[k] & hold_valid_q & hold_hit[k]) ?
                           hold_hit_data[k] : src_data_q[k];
      end
   end

   assign q_src_data_o = src_data_out;
   assign q_preg_o     = preg_q;
   assign q_payload_o  = payload_q;

   // Next state; flush outranks accept, accept outranks held progress.
   always_comb begin
      hold_valid_d = hold_valid_q;
      lane_valid_d = lane_valid_q;
      sent_d       = sent_q;
      unit_d       = unit_q;
      preg_d       = preg_q;
      src_preg_d   = src_preg_q;
      src_data_d   = src_data_q;
      src_rdy_d    = src_rdy_q;
      payload_d    = payload_q;
      if (flush_i) begin
         hold_valid_d = 1'b0;
         sent_d       = '0;
      end else if (accept) begin
         hold_valid_d = 1'b1;
         lane_valid_d = in_lane_valid_i;
         sent_d       = '0;
         unit_d       = in_unit;
         preg_d       = in_preg_i;
         src_preg_d   = in_src_preg;
         payload_d    = in_payload_i;
         for (int k = 0; k < NOPS; k++) begin
            src_rdy_d[k]  = in_src_rdy_i[k];
            src_data_d[k] = in_src_data[k];
            if (!in_src_rdy_i[k]) begin
               if (in_src_preg[k] == '0) begin
                  src_rdy_d[k]  = 1'b1;
                  src_data_d[k] = '0;
               end else if (in_hit[k]) begin
                  src_rdy_d[k]  = 1'b1;
                  src_data_d[k] = in_hit_data[k];
               end
            end
         end
      end else if (hold_valid_q) begin
         for (int k = 0; k < NOPS; k++) begin
            if (!src_rdy_q[k] && hold_hit[k]) begin
               src_rdy_d[k]  = 1'b1;
               src_data_d[k] = hold_hit_data[k];
            end
         end
         if (done) begin
            hold_valid_d = 1'b0;
            sent_d       = '0;
         end else begin
            sent_d = sent_q | fire;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_q <= 1'b0;
         lane_valid_q <= '0;
         sent_q       <= '0;
         unit_q       <= '0;
         preg_q       <= '0;
         src_preg_q   <= '0;
         src_data_q   <= '0;
         src_rdy_q    <= '0;
         payload_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         lane_valid_q <= lane_valid_d;
         sent_q       <= sent_d;
         unit_q       <= unit_d;
         preg_q       <= preg_d;
         src_preg_q   <= src_preg_d;
         src_data_q   <= src_data_d;
         src_rdy_q    <= src_rdy_d;
         payload_q    <= payload_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_p_dispatch_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_dispatch_multi
// Purpose  : Self-checking bench for p_dispatch_multi. Directed scenarios
//            followed by randomized cycles, all compared against a lane-list
//            reference model of the held group.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p_dispatch_multi;
   localparam int W  = 2;
   localparam int NA = 2;
   localparam int NQ = NA + 2;
   localparam int CP = 2;
   localparam int DW = 32;
   localparam int PW = 6;
   localparam int YW = 128;
   localparam int NO = W * 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush_i = 1'b0;
   logic               in_valid_i = 1'b0;
   logic               in_ready_o;
   logic [W-1:0]       in_lane_valid_i = '0;
   logic [W*2-1:0]     in_unit_i = '0;
   logic [W*PW-1:0]    in_preg_i = '0;
   logic [NO*PW-1:0]   in_src_preg_i = '0;
   logic [NO*DW-1:0]   in_src_data_i = '0;
   logic [NO-1:0]      in_src_rdy_i = '0;
   logic [W*YW-1:0]    in_payload_i = '0;
   logic [CP-1:0]      cdb_valid_i = '0;
   logic [CP*PW-1:0]   cdb_preg_i = '0;
   logic [CP*DW-1:0]   cdb_data_i = '0;
   logic [NQ-1:0]      q_valid_o;
   logic [NQ-1:0]      q_ready_i = '0;
   logic [NQ*W-1:0]    q_mask_o;
   logic [NO*DW-1:0]   q_src_data_o;
   logic [NO-1:0]      q_src_rdy_o;
   logic [W*PW-1:0]    q_preg_o;
   logic [W*YW-1:0]    q_payload_o;
   logic [W-1:0]       rob_issue_o;

   p_dispatch_multi #(
      .WIDTH(W), .NUM_ALU(NA), .CDB_PORTS(CP), .DATA_W(DW), .PREG_W(PW), .PAYLOAD_W(YW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_lane_valid_i(in_lane_valid_i), .in_unit_i(in_unit_i), .in_preg_i(in_preg_i),
      .in_src_preg_i(in_src_preg_i), .in_src_data_i(in_src_data_i),
      .in_src_rdy_i(in_src_rdy_i), .in_payload_i(in_payload_i),
      .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i), .cdb_data_i(cdb_data_i),
      .q_valid_o(q_valid_o), .q_ready_i(q_ready_i), .q_mask_o(q_mask_o),
      .q_src_data_o(q_src_data_o), .q_src_rdy_o(q_src_rdy_o),
      .q_preg_o(q_preg_o), .q_payload_o(q_payload_o), .rob_issue_o(rob_issue_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model of the held group
   logic              m_hold = 1'b0;
   logic              m_ever = 1'b0;
   logic [W-1:0]      m_lv = '0;
   logic [W-1:0]      m_sent = '0;
   logic [1:0]        m_unit [W];
   logic [PW-1:0]     m_preg [W];
   logic [YW-1:0]     m_pay  [W];
   logic [PW-1:0]     m_srcp [NO];
   logic [DW-1:0]     m_data [NO];
   logic [NO-1:0]     m_rdy = '0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Queue index a lane goes to, -1 for ROB-only.
   function automatic int target(input logic [1:0] u, input logic [PW-1:0] p);
      case (u)
         2'd0:    return int'(p) % NA;
         2'd1:    return NA;
         2'd2:    return NA + 1;
         default: return -1;
      endcase
   endfunction

   function automatic logic cdb_lookup(input logic [PW-1:0] p, output logic [DW-1:0] d);
      logic hit;
      hit = 1'b0;
      d   = '0;
      for (int c = 0; c < CP; c++) begin
         if (cdb_valid_i[c] && cdb_preg_i[c*PW +: PW] == p) begin
            hit = 1'b1;
            d   = cdb_data_i[c*DW +: DW];
         end
      end
      return hit;
   endfunction

   // Called at a falling edge with inputs already applied: checks the
   // outputs, advances the model across the next rising edge, and returns
   // at the following falling edge.
   task automatic do_cycle();
      logic [NQ-1:0]    e_qv;
      logic [NQ*W-1:0]  e_mask;
      logic [W-1:0]     e_fire;
      logic             e_done, e_rdy, blocked, hit;
      logic [NO-1:0]    e_srdy;
      logic [NO*DW-1:0] e_sdata, dmask;
      logic [DW-1:0]    hd;
      int               tq;
      #1;
      e_mask  = '0;
      e_fire  = '0;
      blocked = 1'b0;
      if (m_hold) begin
         for (int i = 0; i < W; i++) begin
            if (m_lv[i] && !m_sent[i] && !blocked) begin
               tq = target(m_unit[i], m_preg[i]);
               if (tq >= 0) e_mask[tq*W + i] = 1'b1;
               if (tq < 0 || q_ready_i[tq]) e_fire[i] = 1'b1;
               else blocked = 1'b1;
            end
         end
      end
      e_done = m_hold && !blocked;
      e_rdy  = !flush_i && (!m_hold || e_done);
      for (int q = 0; q < NQ; q++) e_qv[q] = !flush_i && (|e_mask[q*W +: W]);

      chk("q_valid", q_valid_o, e_qv);
      if (!flush_i) chk("q_mask", q_mask_o, e_mask);
      chk("rob_issue", rob_issue_o, flush_i ? '0 : e_fire);
      chk("in_ready", in_ready_o, e_rdy);
      if (!m_ever) begin
         chk("idle_bus", {q_src_rdy_o, q_preg_o, q_src_data_o}, '0);
         chk("idle_payload", q_payload_o, '0);
      end else if (m_hold) begin
         e_sdata = '0;
         dmask   = '0;
         for (int k = 0; k < NO; k++) begin
            hit       = cdb_lookup(m_srcp[k], hd);
            e_srdy[k] = m_rdy[k] | hit;
            e_sdata[k*DW +: DW] = m_rdy[k] ? m_data[k] : hd;
            dmask[k*DW +: DW]   = {DW{e_srdy[k]}};
         end
         chk("src_rdy", q_src_rdy_o, e_srdy);
         chk("src_data", q_src_data_o & dmask, e_sdata & dmask);
         chk("preg_bus", q_preg_o, {m_preg[1], m_preg[0]});
         chk("payload_bus", q_payload_o, {m_pay[1], m_pay[0]});
      end

      if (flush_i) begin
         m_hold = 1'b0;
         m_sent = '0;
      end else if (in_valid_i && e_rdy) begin
         m_hold = 1'b1;
         m_ever = 1'b1;
         m_lv   = in_lane_valid_i;
         m_sent = '0;
         for (int i = 0; i < W; i++) begin
            m_unit[i] = in_unit_i[2*i +: 2];
            m_preg[i] = in_preg_i[PW*i +: PW];
            m_pay[i]  = in_payload_i[YW*i +: YW];
         end
         for (int k = 0; k < NO; k++) begin
            m_srcp[k] = in_src_preg_i[PW*k +: PW];
            m_data[k] = in_src_data_i[DW*k +: DW];
            m_rdy[k]  = in_src_rdy_i[k];
            if (!m_rdy[k] && m_srcp[k] == '0) begin
               m_rdy[k]  = 1'b1;
               m_data[k] = '0;
            end
            if (!m_rdy[k] && cdb_lookup(m_srcp[k], hd)) begin
               m_rdy[k]  = 1'b1;
               m_data[k] = hd;
            end
         end
      end else if (m_hold) begin
         for (int k = 0; k < NO; k++) begin
            if (!m_rdy[k] && cdb_lookup(m_srcp[k], hd)) begin
               m_rdy[k]  = 1'b1;
               m_data[k] = hd;
            end
         end
         if (e_done) begin
            m_hold = 1'b0;
            m_sent = '0;
         end else begin
            m_sent = m_sent | e_fire;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid_i  = 1'b0;
      flush_i     = 1'b0;
      cdb_valid_i = '0;
   endtask

   task automatic set_group(input logic [W-1:0] lv, input logic [1:0] u0, input logic [1:0] u1,
                            input logic [PW-1:0] p0, input logic [PW-1:0] p1);
      in_valid_i      = 1'b1;
      in_lane_valid_i = lv;
      in_unit_i       = {u1, u0};
      in_preg_i       = {p1, p0};
      in_src_preg_i   = '0;
      in_src_rdy_i    = '1;
      in_src_data_i   = {$urandom, $urandom, $urandom, $urandom};
      in_payload_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic rand_inputs();
      flush_i         = ($urandom_range(0, 19) == 0);
      in_valid_i      = ($urandom_range(0, 3) != 0);
      in_lane_valid_i = W'($urandom);
      in_unit_i       = (W*2)'($urandom);
      in_preg_i       = (W*PW)'($urandom);
      for (int k = 0; k < NO; k++) in_src_preg_i[k*PW +: PW] = PW'($urandom_range(0, 15));
      in_src_rdy_i    = NO'($urandom);
      in_src_data_i   = {$urandom, $urandom, $urandom, $urandom};
      in_payload_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cdb_valid_i     = CP'($urandom);
      for (int c = 0; c < CP; c++) begin
         cdb_preg_i[c*PW +: PW] = PW'($urandom_range(1, 15));
         cdb_data_i[c*DW +: DW] = $urandom;
      end
      // Write-back ports never carry the same preg in one cycle.
      if (cdb_preg_i[PW-1:0] == cdb_preg_i[2*PW-1:PW]) cdb_valid_i[1] = 1'b0;
      q_ready_i       = NQ'($urandom) | NQ'($urandom);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_q_valid", q_valid_o, '0);
      chk("rst_rob", rob_issue_o, '0);
      chk("rst_bus", {q_mask_o, q_src_rdy_o, q_preg_o, q_src_data_o}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle();

      // Two ALU lanes, all queues ready
      q_ready_i = 4'b1111;
      set_group(2'b11, 2'd0, 2'd0, 6'd4, 6'd5);
      do_cycle();
      idle();
      #1;
      chk("t1_q_valid", q_valid_o, 4'b0011);
      chk("t1_mask", q_mask_o, 8'b0000_1001);
      chk("t1_rob", rob_issue_o, 2'b11);
      chk("t1_in_ready", in_ready_o, 1'b1);
      do_cycle();

      // Partial dispatch: MDU ready, LSU stalled
      q_ready_i = 4'b0100;
      set_group(2'b11, 2'd1, 2'd2, 6'd0, 6'd0);
      do_cycle();
      idle();
      #1;
      chk("t2_rob_first", rob_issue_o, 2'b01);
      chk("t2_qv_first", q_valid_o, 4'b1100);
      do_cycle();
      do_cycle();
      #1;
      chk("t2_qv_third", q_valid_o, 4'b1000);
      chk("t2_rob_third", rob_issue_o, 2'b00);
      do_cycle();
      q_ready_i = 4'b1000;
      #1;
      chk("t2_rob_last", rob_issue_o, 2'b10);
      chk("t2_in_ready", in_ready_o, 1'b1);
      do_cycle();

      // In-order block: LSU lane 0 stalls ALU lane 1
      q_ready_i = 4'b0111;
      set_group(2'b11, 2'd2, 2'd0, 6'd0, 6'd0);
      do_cycle();
      idle();
      #1;
      chk("t3_q_valid", q_valid_o, 4'b1000);
      chk("t3_rob_blocked", rob_issue_o, 2'b00);
      do_cycle();
      q_ready_i = 4'b1111;
      #1;
      chk("t3_rob_both", rob_issue_o, 2'b11);
      do_cycle();

      // Held wakeup of lane 0 src0 (preg 9)
      q_ready_i = 4'b0000;
      set_group(2'b01, 2'd0, 2'd0, 6'd4, 6'd0);
      in_src_preg_i[PW-1:0] = 6'd9;
      in_src_rdy_i[0]       = 1'b0;
      do_cycle();
      idle();
      do_cycle();
      cdb_valid_i = 2'b01;
      cdb_preg_i  = {6'd0, 6'd9};
      cdb_data_i  = {32'h0, 32'hDEAD_BEEF};
      #1;
      chk("t4_bypass_rdy", q_src_rdy_o[0], 1'b1);
      chk("t4_bypass_data", q_src_data_o[DW-1:0], 32'hDEAD_BEEF);
      do_cycle();
      idle();
      #1;
      chk("t4_kept_data", q_src_data_o[DW-1:0], 32'hDEAD_BEEF);
      do_cycle();
      cdb_valid_i = 2'b01;
      cdb_data_i  = {32'h0, 32'h1};
      #1;
      chk("t4_no_overwrite", q_src_data_o[DW-1:0], 32'hDEAD_BEEF);
      do_cycle();
      idle();
      q_ready_i = 4'b1111;
      do_cycle();

      // Back-to-back groups
      for (int g = 0; g < 5; g++) begin
         set_group(2'b11, 2'd0, 2'd0, PW'($urandom), PW'($urandom));
         if (g > 0) begin
            #1;
            chk("t5_rob", rob_issue_o, 2'b11);
            chk("t5_in_ready", in_ready_o, 1'b1);
         end
         do_cycle();
      end
      idle();
      do_cycle();

      // Flush mid-stall, with a new group arriving during the flush
      q_ready_i = 4'b0001;
      set_group(2'b11, 2'd0, 2'd2, 6'd4, 6'd0);
      do_cycle();
      idle();
      do_cycle();
      set_group(2'b11, 2'd0, 2'd0, 6'd4, 6'd5);
      flush_i   = 1'b1;
      q_ready_i = 4'b1111;
      #1;
      chk("t6_flush_qv", q_valid_o, 4'b0000);
      chk("t6_flush_rob", rob_issue_o, 2'b00);
      chk("t6_flush_ready", in_ready_o, 1'b0);
      do_cycle();
      idle();
      #1;
      chk("t6_after_ready", in_ready_o, 1'b1);
      chk("t6_after_qv", q_valid_o, 4'b0000);
      chk("t6_after_rob", rob_issue_o, 2'b00);
      do_cycle();

      // Asynchronous reset while a group is held
      q_ready_i = 4'b0000;
      set_group(2'b11, 2'd0, 2'd0, 6'd4, 6'd5);
      do_cycle();
      idle();
      #1;
      chk("t7_held_qv", q_valid_o, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("t7_rst_qv", q_valid_o, 4'b0000);
      chk("t7_rst_mask", q_mask_o, '0);
      m_hold = 1'b0;
      m_sent = '0;
      m_rdy  = '0;
      m_ever = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle();

      // Randomized traffic
      repeat (400) begin
         rand_inputs();
         do_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
